vram_port_scheduler: RTL and testbench
======================================

VRAM_PORT_SCHEDULER -- requirements
Module: vram_port_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, VRAM word-address width.
REQ-002 SHALL have parameter RD_LAT, default 1, RAM read latency in cycles (1 or 2).
REQ-003 SHALL have parameter FAIR_N, default 4, maximum consecutive cycles a pending fill slot may be denied.
REQ-004 SHALL have port S_AXI_ACLK  in  1  clock; one clock domain.
REQ-005 SHALL have port S_AXI_ARESETN  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port host_req  in  1  host access request, held until granted.
REQ-007 SHALL have port host_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports host_addr  in  ADDR_W, host_wdata  in  32, host_wstrb  in  4: the access fields.
REQ-009 SHALL have port host_gnt  out  1  host request accepted this cycle.
REQ-010 SHALL have ports host_rvalid  out  1 and host_rdata  out  32: read return.
REQ-011 SHALL have ports fill_start  in  1, fill_base  in  ADDR_W, fill_count  in  12, fill_word  in  32: fill command.
REQ-012 SHALL have ports fill_busy  out  1 and fill_done  out  1 (one-cycle pulse).
REQ-013 SHALL have ports ram_addr  out  ADDR_W, ram_we  out  4, ram_din  out  32, ram_dout  in  32: VRAM port A.

Function
REQ-014 SHALL grant at most one requester per cycle; host_gnt is combinational from host_req and arbitration state.
REQ-015 SHALL register a granted access onto ram_addr/ram_we/ram_din in the cycle after grant; ram_we = host_wstrb for a host write and 0 for a read.
REQ-016 SHALL drive ram_we = 0 and hold ram_addr in cycles with no grant.
REQ-017 SHALL assert host_rvalid for exactly one cycle, at grant cycle T + 2 + RD_LAT, with host_rdata = ram_dout registered; writes return no rvalid.
REQ-018 SHALL track reads in a RD_LAT+1 deep valid pipeline so back-to-back reads return in order, one per cycle.
REQ-019 SHALL implement fill FSM IDLE -> RUN -> DONE -> IDLE.
REQ-020 In IDLE, SHALL accept fill_start by latching base, count and word; count != 0 -> RUN, count == 0 -> DONE.
REQ-021 In RUN, SHALL on each fill grant write fill_word to the current address with ram_we = 4'hF, increment the address modulo 2^ADDR_W and decrement the remaining count.
REQ-022 SHALL move to DONE in the cycle after the last fill write is granted; DONE asserts fill_done for one cycle, then goes to IDLE.
REQ-023 SHALL hold fill_busy = 1 in RUN and DONE, and 0 in IDLE.
REQ-024 SHALL ignore fill_start outside IDLE.
REQ-025 Arbitration: host wins by default. A starvation counter counts cycles in RUN where the fill is denied. When it reaches FAIR_N, the fill wins the next cycle and host_gnt = 0. The counter clears on every fill grant.
REQ-026 SHALL grant fill every cycle in RUN while host_req = 0.

Reset
REQ-027 SHALL on S_AXI_ARESETN = 0 at a clock edge force: FSM to IDLE; host_gnt, host_rvalid, fill_busy and fill_done to 0; host_rdata, ram_addr, ram_din and ram_we to 0; read pipeline and starvation counter to 0.
REQ-028 Reset during RUN SHALL abort the fill without a fill_done pulse; in-flight reads SHALL be discarded.

Configuration
REQ-029 SHALL support macro VRAM_SCHED_FILL_EN.
REQ-030 With VRAM_SCHED_FILL_EN defined, the fill engine and fairness arbitration SHALL be present as specified.
REQ-031 With VRAM_SCHED_FILL_EN undefined: fill inputs are ignored, fill_busy = fill_done = 0, and host_gnt = host_req every cycle; host timing is unchanged.

Verification
REQ-032 Host read of addr 0x005 (RAM preloaded 0xDEADBEEF), RD_LAT=1, req at T -> gnt at T, ram_addr=0x005 at T+1, host_rvalid=1 with 0xDEADBEEF at T+3 only.
REQ-033 Host write addr 0x010, data 0x12345678, wstrb 4'b0011 -> ram_we=4'b0011 for one cycle at T+1, no host_rvalid.
REQ-034 Fill base 0x7FE, count 4, word 0x00200741, host idle -> writes to 0x7FE, 0x7FF, 0x000, 0x001 on consecutive cycles; fill_done pulses once; fill_busy falls after it.
REQ-035 Fill count 8 with host_req held continuously, FAIR_N=4 -> each fill write follows 4 host grants, host_gnt = 0 on those cycles; all 8 writes complete.
REQ-036 Fill count 0 -> no ram_we, fill_done pulses one cycle after fill_start; fill_start issued during RUN -> ignored, original count completes.
REQ-037 Reset asserted mid-fill after 3 of 10 writes -> no further writes, no fill_done, all outputs 0 the following cycle.

Source files
------------

// File: rtl/vram_port_scheduler_if.sv
// Bundles the host access port, the fill command port and VRAM port A of vram_port_scheduler.
// The master side is the system around the scheduler, and the slave side is the scheduler.
interface vram_port_scheduler_if #(
  parameter int ADDR_W = 11
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic [3:0]        host_wstrb;
  logic              host_gnt;
  logic              host_rvalid;
  logic [31:0]       host_rdata;

  logic              fill_start;
  logic [ADDR_W-1:0] fill_base;
  logic [11:0]       fill_count;
  logic [31:0]       fill_word;
  logic              fill_busy;
  logic              fill_done;

  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport master (
    output host_req, host_we, host_addr, host_wdata, host_wstrb,
    input  host_gnt, host_rvalid, host_rdata,
    output fill_start, fill_base, fill_count, fill_word,
    input  fill_busy, fill_done,
    input  ram_addr, ram_we, ram_din,
    output ram_dout
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, host_wstrb,
    output host_gnt, host_rvalid, host_rdata,
    input  fill_start, fill_base, fill_count, fill_word,
    output fill_busy, fill_done,
    output ram_addr, ram_we, ram_din,
    input  ram_dout
  );
endinterface

// File: rtl/vram_port_scheduler.sv
// VRAM port A scheduler that arbitrates host accesses against a block-fill engine.
// The fill engine and its fairness arbitration are built only when VRAM_SCHED_FILL_EN is defined.
module vram_port_scheduler #(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1,
  parameter int FAIR_N = 4
) (
  input logic                  S_AXI_ACLK,
  input logic                  S_AXI_ARESETN,
  vram_port_scheduler_if.slave bus
);

  localparam int CNT_W = (FAIR_N < 1) ? 1 : $clog2(FAIR_N + 1);

  logic              host_gnt;
  logic              fill_gnt;
  logic [ADDR_W-1:0] fill_addr;
  logic [31:0]       fill_data;
  logic              fill_busy;
  logic              fill_done;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]        ram_we_q, ram_we_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic [RD_LAT:0]   rd_pipe_q, rd_pipe_d;
  logic              host_rvalid_q;
  logic [31:0]       host_rdata_q, host_rdata_d;

`ifdef VRAM_SCHED_FILL_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} fill_state_e;

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [11:0]       fill_left_q, fill_left_d;
  logic [31:0]       fill_word_q, fill_word_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              fill_forced;

  // Host wins unless the fill has been denied FAIR_N times in a row.
  assign fill_forced = (state_q == RUN) && (starve_q >= CNT_W'(FAIR_N));
  assign host_gnt    = S_AXI_ARESETN && bus.host_req && !fill_forced;
  assign fill_gnt    = S_AXI_ARESETN && (state_q == RUN) && !host_gnt;
  assign fill_addr   = fill_addr_q;
  assign fill_data   = fill_word_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      fill_left_q <= '0;
      fill_word_q <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      fill_left_q <= fill_left_d;
      fill_word_q <= fill_word_d;
      starve_q    <= starve_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_left_d = fill_left_q;
    fill_word_d = fill_word_q;
    starve_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.fill_start) begin
          fill_addr_d = bus.fill_base;
          fill_left_d = bus.fill_count;
          fill_word_d = bus.fill_word;
          state_d     = (bus.fill_count == 12'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (fill_gnt) begin
          fill_addr_d = fill_addr_q + 1'b1;
          fill_left_d = fill_left_q - 12'd1;
          if (fill_left_q == 12'd1) state_d = DONE;
        end else begin
          starve_d = starve_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_busy = 1'b0;
    fill_done = 1'b0;
    unique case (state_q)
      RUN:  fill_busy = 1'b1;
      DONE: begin
        fill_busy = 1'b1;
        fill_done = 1'b1;
      end
      default: ;
    endcase
  end
`else
  logic unused_fill;

  assign unused_fill = ^{bus.fill_start, bus.fill_base, bus.fill_count, bus.fill_word};
  assign host_gnt    = S_AXI_ARESETN && bus.host_req;
  assign fill_gnt    = 1'b0;
  assign fill_addr   = '0;
  assign fill_data   = '0;
  assign fill_busy   = 1'b0;
  assign fill_done   = 1'b0;
`endif

  // The address is held between grants; the write enable is only ever a one-cycle pulse.
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_we_d   = 4'h0;
    ram_din_d  = ram_din_q;
    if (host_gnt) begin
      ram_addr_d = bus.host_addr;
      ram_we_d   = bus.host_we ? bus.host_wstrb : 4'h0;
      ram_din_d  = bus.host_wdata;
    end else if (fill_gnt) begin
      ram_addr_d = fill_addr;
      ram_we_d   = 4'hF;
      ram_din_d  = fill_data;
    end
    rd_pipe_d    = {rd_pipe_q[RD_LAT-1:0], host_gnt && !bus.host_we};
    host_rdata_d = rd_pipe_q[RD_LAT] ? bus.ram_dout : host_rdata_q;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      ram_addr_q    <= '0;
      ram_we_q      <= '0;
      ram_din_q     <= '0;
      rd_pipe_q     <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_din_q     <= ram_din_d;
      rd_pipe_q     <= rd_pipe_d;
      host_rvalid_q <= rd_pipe_q[RD_LAT];
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign bus.host_gnt    = host_gnt;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.fill_busy   = fill_busy;
  assign bus.fill_done   = fill_done;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_din     = ram_din_q;

endmodule

// File: tb/tb_vram_port_scheduler.sv
// Testbench for vram_port_scheduler: directed and random host/fill traffic checked against a behavioural model.
// The fill-specific expectations follow whether VRAM_SCHED_FILL_EN is defined.
module tb_vram_port_scheduler;

  localparam int ADDR_W = 11;
  localparam int RD_LAT = 1;
  localparam int FAIR_N = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  vram_port_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  vram_port_scheduler #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FAIR_N(FAIR_N)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rstn),
    .bus          (bus)
  );

  // Behavioural VRAM with a one-cycle read-first port.
  logic [31:0] ramMem [DEPTH];
  logic [31:0] ramRead;

  always @(posedge clk) begin
    ramRead <= ramMem[bus.ram_addr];
    for (int b = 0; b < 4; b++)
      if (bus.ram_we[b]) ramMem[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
  end

  assign bus.ram_dout = ramRead;

  // Reference model state: memory image as seen by program order, plus fill progress.
  logic [31:0]       shadow [DEPTH];
  logic [31:0]       rdAt [int];
  int                cycle;
  int                checks;
  int                errors;
  bit                modelValid;
  bit                expGnt;
  bit                fillGnt;
  logic [ADDR_W-1:0] expRamAddr;
  logic [3:0]        expRamWe;
  logic [31:0]       expRamDin;
  logic [31:0]       expRdata;
  bit                fillRunning;
  bit                fillDonePending;
  int                fillLeft;
  int                denied;
  logic [ADDR_W-1:0] fillAddr;
  logic [31:0]       fillWord;
  logic [31:0]       seedWord;
  int                memDiffs;

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic void writeShadow(logic [ADDR_W-1:0] addr, logic [31:0] data, logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) shadow[addr][8*b +: 8] = data[8*b +: 8];
  endfunction

  function automatic void updateModel();
    if (!rstn) begin
      fillRunning     = 1'b0;
      fillDonePending = 1'b0;
      fillLeft        = 0;
      denied          = 0;
      expRamAddr      = '0;
      expRamWe        = '0;
      expRamDin       = '0;
      expRdata        = '0;
      rdAt.delete();
      modelValid      = 1'b1;
      return;
    end
    expRamWe = 4'h0;
    if (expGnt) begin
      expRamAddr = bus.host_addr;
      expRamDin  = bus.host_wdata;
      if (bus.host_we) begin
        expRamWe = bus.host_wstrb;
        writeShadow(bus.host_addr, bus.host_wdata, bus.host_wstrb);
      end else begin
        rdAt[cycle + 2 + RD_LAT] = shadow[bus.host_addr];
      end
    end else if (fillGnt) begin
      expRamAddr = fillAddr;
      expRamDin  = fillWord;
      expRamWe   = 4'hF;
      writeShadow(fillAddr, fillWord, 4'hF);
    end
    if (fillDonePending) begin
      fillDonePending = 1'b0;
    end else if (fillRunning) begin
      if (fillGnt) begin
        fillAddr = ADDR_W'((int'(fillAddr) + 1) % DEPTH);
        fillLeft--;
        denied = 0;
        if (fillLeft == 0) begin
          fillRunning     = 1'b0;
          fillDonePending = 1'b1;
        end
      end else begin
        denied++;
      end
    end else begin
`ifdef VRAM_SCHED_FILL_EN
      if (bus.fill_start) begin
        fillAddr = bus.fill_base;
        fillWord = bus.fill_word;
        fillLeft = int'(bus.fill_count);
        denied   = 0;
        if (fillLeft == 0) fillDonePending = 1'b1;
        else               fillRunning     = 1'b1;
      end
`endif
    end
  endfunction

  // One clock cycle with the currently driven inputs: predict, check at negedge, advance model.
  task automatic applyStimulus();
    bit forced;
    bit rv;
    forced  = fillRunning && (denied >= FAIR_N);
    expGnt  = rstn && bus.host_req && !forced;
    fillGnt = rstn && fillRunning && !expGnt;
    @(negedge clk);
    checkOutput("host_gnt", 32'(bus.host_gnt), 32'(expGnt));
    if (modelValid) begin
      rv = rdAt.exists(cycle);
      if (rv) begin
        expRdata = rdAt[cycle];
        rdAt.delete(cycle);
      end
      checkOutput("fill_busy", 32'(bus.fill_busy), 32'(fillRunning || fillDonePending));
      checkOutput("fill_done", 32'(bus.fill_done), 32'(fillDonePending));
      checkOutput("ram_we", 32'(bus.ram_we), 32'(expRamWe));
      checkOutput("ram_addr", 32'(bus.ram_addr), 32'(expRamAddr));
      checkOutput("ram_din", bus.ram_din, expRamDin);
      checkOutput("host_rvalid", 32'(bus.host_rvalid), 32'(rv));
      checkOutput("host_rdata", bus.host_rdata, expRdata);
    end
    @(posedge clk);
    updateModel();
    cycle++;
    #1;
  endtask

  task automatic idleCycles(int n);
    bus.host_req = 1'b0;
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic hostAccess(bit we, logic [ADDR_W-1:0] addr, logic [31:0] data, logic [3:0] strb);
    int waited;
    waited         = 0;
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = data;
    bus.host_wstrb = strb;
    do begin
      applyStimulus();
      waited++;
    end while (!expGnt && waited < 64);
    bus.host_req = 1'b0;
  endtask

  task automatic startFill(logic [ADDR_W-1:0] base, logic [11:0] count, logic [31:0] word);
    bus.fill_start = 1'b1;
    bus.fill_base  = base;
    bus.fill_count = count;
    bus.fill_word  = word;
    applyStimulus();
    bus.fill_start = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cycle = 0; modelValid = 1'b0;
    expGnt = 1'b0; fillGnt = 1'b0; fillRunning = 1'b0; fillDonePending = 1'b0;
    fillLeft = 0; denied = 0; fillAddr = '0; fillWord = '0;
    expRamAddr = '0; expRamWe = '0; expRamDin = '0; expRdata = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0;
    bus.host_wdata = '0; bus.host_wstrb = '0;
    bus.fill_start = 1'b0; bus.fill_base = '0; bus.fill_count = '0; bus.fill_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      seedWord  = $urandom;
      ramMem[i] <= seedWord;
      shadow[i] = seedWord;
    end
    ramMem[5] <= 32'hDEADBEEF;
    shadow[5] = 32'hDEADBEEF;

    // Reset with a request pending: no grant may leak out while reset is held.
    rstn = 1'b0;
    bus.host_req = 1'b1;
    applyStimulus();
    applyStimulus();
    bus.host_req = 1'b0;
    rstn = 1'b1;
    idleCycles(2);

    $display("[TB] host read of preloaded word and strobed write");
    hostAccess(1'b0, 11'h005, 32'h0, 4'h0);
    idleCycles(5);
    hostAccess(1'b1, 11'h010, 32'h12345678, 4'b0011);
    idleCycles(3);
    hostAccess(1'b0, 11'h010, 32'h0, 4'h0);
    idleCycles(5);

    $display("[TB] fill across the top of the address space");
    startFill(11'h7FE, 12'd4, 32'h00200741);
    idleCycles(8);
`ifdef VRAM_SCHED_FILL_EN
    checkOutput("fill_wrap_7FE", ramMem[11'h7FE], 32'h00200741);
    checkOutput("fill_wrap_000", ramMem[11'h000], 32'h00200741);
    checkOutput("fill_wrap_001", ramMem[11'h001], 32'h00200741);
`endif

    $display("[TB] fill of 8 against a continuously held host read stream");
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = ADDR_W'($urandom_range(63));
    startFill(11'h100, 12'd8, 32'hA5A5_0F0F);
    for (int i = 0; i < 45; i++) begin
      if (expGnt) bus.host_addr = ADDR_W'($urandom_range(63));
      applyStimulus();
    end
    idleCycles(6);
`ifdef VRAM_SCHED_FILL_EN
    checkOutput("fill8_first", ramMem[11'h100], 32'hA5A5_0F0F);
    checkOutput("fill8_last", ramMem[11'h107], 32'hA5A5_0F0F);
`endif

    $display("[TB] zero-length fill and fill_start while running");
    startFill(11'h180, 12'd0, 32'hFFFF_FFFF);
    idleCycles(3);
    startFill(11'h200, 12'd6, 32'h1357_9BDF);
    idleCycles(2);
    startFill(11'h300, 12'd2, 32'h2468_ACE0);
    idleCycles(10);
`ifdef VRAM_SCHED_FILL_EN
    checkOutput("fill6_last", ramMem[11'h205], 32'h1357_9BDF);
`endif

    $display("[TB] random host and fill traffic");
    for (int i = 0; i < 400; i++) begin
      if (!bus.host_req || expGnt) begin
        bus.host_req   = ($urandom_range(99) < 60);
        bus.host_we    = 1'($urandom_range(1));
        bus.host_addr  = ($urandom_range(3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(15));
        bus.host_wdata = $urandom;
        bus.host_wstrb = 4'($urandom_range(15));
      end
      bus.fill_start = ($urandom_range(99) < 5);
      bus.fill_base  = ADDR_W'($urandom);
      bus.fill_count = 12'($urandom_range(6));
      bus.fill_word  = $urandom;
      applyStimulus();
    end
    bus.fill_start = 1'b0;
    idleCycles(12);

    $display("[TB] reset in the middle of a fill");
    startFill(11'h400, 12'd10, 32'hC0DE_CAFE);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    rstn = 1'b0;
    applyStimulus();
    rstn = 1'b1;
    idleCycles(6);
`ifdef VRAM_SCHED_FILL_EN
    checkOutput("abort_third_write", ramMem[11'h402], 32'hC0DE_CAFE);
`endif

    memDiffs = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ramMem[i] !== shadow[i]) memDiffs++;
    checkOutput("mem_image_diffs", 32'(memDiffs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
